// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO; frames go out back-to-back while words are queued.
// Optional parity bit is enabled by defining UART_TX_PARITY_EN.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 15,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          vld_tx,
  input  logic [DATA_W-1:0]             d_tx,
  output logic                          rdy_tx,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned CW        = AW + 1;
  localparam int unsigned STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int unsigned BW        = $clog2(STOP_CLKS);
  localparam int unsigned IW        = $clog2(DATA_W);

  if (DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_tx_fifo: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PAR,
`endif
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic                txd_q, txd_d;
  logic [AW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                rdy_q, rdy_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   head;
  logic                push, pop;
`ifdef UART_TX_PARITY_EN
  logic                par_q, par_d;
`endif

  assign push = vld_tx & rdy_q;
  assign head = mem_q[rptr_q];

  // FIFO storage: no reset needed, pointers/count define validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= d_tx;
  end

  // Next-state: FIFO bookkeeping plus frame sequencing
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    txd_d   = txd_q;
    rptr_d  = rptr_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) pop = 1'b1;
      end
      S_START: begin
        if (bcnt_q == '0) begin
          txd_d   = sh_q[0];
          sh_d    = sh_q >> 1;
          idx_d   = '0;
          bcnt_d  = BW'(CLKS_PER_BIT - 1);
          state_d = S_DATA;
        end else begin
          bcnt_d = bcnt_q - BW'(1);
        end
      end
      S_DATA: begin
        if (bcnt_q == '0) begin
          bcnt_d = BW'(CLKS_PER_BIT - 1);
          if (idx_q == IW'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            txd_d   = par_q;
            state_d = S_PAR;
`else
            txd_d   = 1'b1;
            bcnt_d  = BW'(STOP_CLKS - 1);
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
            txd_d = sh_q[0];
            sh_d  = sh_q >> 1;
          end
        end else begin
          bcnt_d = bcnt_q - BW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PAR: begin
        if (bcnt_q == '0) begin
          txd_d   = 1'b1;
          bcnt_d  = BW'(STOP_CLKS - 1);
          state_d = S_STOP;
        end else begin
          bcnt_d = bcnt_q - BW'(1);
        end
      end
`endif
      S_STOP: begin
        if (bcnt_q == '0) begin
          if (cnt_q != '0) begin
            pop = 1'b1;
          end else begin
            txd_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          bcnt_d = bcnt_q - BW'(1);
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    // A pop always launches a start bit, from IDLE or straight out of STOP
    if (pop) begin
      sh_d    = head;
      txd_d   = 1'b0;
      bcnt_d  = BW'(CLKS_PER_BIT - 1);
      state_d = S_START;
      rptr_d  = rptr_q + AW'(1);
`ifdef UART_TX_PARITY_EN
      par_d   = (^head) ^ 1'(PARITY_ODD);
`endif
    end

    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    rdy_d  = (cnt_d != CW'(FIFO_DEPTH));
    busy_d = (state_d != S_IDLE) | (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign txd      = txd_q;
  assign rdy_tx   = rdy_q;
  assign busy     = busy_q;
  assign fifo_cnt = cnt_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=4; parity case runs when UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int CPB  = 4;
  localparam int DW   = 8;
`ifdef UART_TX_PARITY_EN
  localparam int SB   = 2;
  localparam int PB   = 1;
`else
  localparam int SB   = 1;
  localparam int PB   = 0;
`endif
  localparam int PODD  = 0;
  localparam int NBITS = 1 + DW + PB + SB;

  logic          clk;
  logic          rstn;
  logic          vld_tx;
  logic [DW-1:0] d_tx;
  logic          rdy_tx;
  logic          txd;
  logic          busy;
  logic [2:0]    fifo_cnt;

  int checks   = 0;
  int failures = 0;

  uart_tx_fifo #(
    .DATA_W       (DW),
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (SB),
    .FIFO_DEPTH   (4),
    .PARITY_ODD   (PODD)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .vld_tx   (vld_tx),
    .d_tx     (d_tx),
    .rdy_tx   (rdy_tx),
    .txd      (txd),
    .busy     (busy),
    .fifo_cnt (fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called just after the accept/pop-arming edge; checks txd every cycle of one frame
  task automatic check_frame(input logic [DW-1:0] w);
    logic e;
    @(posedge clk);
    for (int b = 0; b < NBITS; b++) begin
      if (b == 0)                          e = 1'b0;
      else if (b <= DW)                    e = w[b-1];
      else if (PB == 1 && b == DW + 1)     e = (^w) ^ 1'(PODD);
      else                                 e = 1'b1;
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        chk($sformatf("frame_%02h_bit%0d_cyc%0d", w, b, c), 32'(txd), 32'(e));
      end
    end
  endtask

  task automatic push_one(input logic [DW-1:0] w);
    @(negedge clk);
    vld_tx = 1'b1;
    d_tx   = w;
    @(posedge clk);
    #1;
    vld_tx = 1'b0;
    d_tx   = 8'hFF;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_cnt [5];
    exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    rstn   = 1'b0;
    vld_tx = 1'b0;
    d_tx   = '0;
    repeat (3) @(negedge clk);
    chk("rst_txd",  32'(txd),      32'd1);
    chk("rst_rdy",  32'(rdy_tx),   32'd1);
    chk("rst_busy", 32'(busy),     32'd0);
    chk("rst_cnt",  32'(fifo_cnt), 32'd0);
    rstn = 1'b1;

    // Idle after reset
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_txd",  32'(txd),      32'd1);
      chk("idle_rdy",  32'(rdy_tx),   32'd1);
      chk("idle_busy", 32'(busy),     32'd0);
      chk("idle_cnt",  32'(fifo_cnt), 32'd0);
    end

    // Single frame 8'hA5
    push_one(8'hA5);
    chk("a5_pre_start_txd", 32'(txd), 32'd1);
    chk("a5_accept_busy",   32'(busy), 32'd1);
    check_frame(8'hA5);
    chk("a5_busy_last_stop", 32'(busy), 32'd1);
    @(negedge clk);
    chk("a5_busy_done", 32'(busy), 32'd0);
    chk("a5_txd_done",  32'(txd),  32'd1);
    chk("a5_cnt_done",  32'(fifo_cnt), 32'd0);

    // Five consecutive pushes: all accepted, sent back-to-back
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (i > 0) chk($sformatf("burst_cnt_%0d", i - 1), 32'(fifo_cnt), 32'(exp_cnt[i-1]));
          vld_tx = 1'b1;
          d_tx   = 8'(i + 1);
          chk($sformatf("burst_rdy_%0d", i), 32'(rdy_tx), 32'd1);
          @(posedge clk);
        end
        #1;
        vld_tx = 1'b0;
        d_tx   = 8'hFF;
        @(negedge clk);
        chk("burst_cnt_full", 32'(fifo_cnt), 32'd4);
        chk("burst_rdy_full", 32'(rdy_tx),   32'd0);
      end
      begin
        @(negedge clk);
        @(posedge clk);
        check_frame(8'h01);
        chk("full_cnt_before_pop", 32'(fifo_cnt), 32'd4);
        chk("full_rdy_before_pop", 32'(rdy_tx),   32'd0);
        check_frame(8'h02);
        chk("cnt_after_pop", 32'(fifo_cnt), 32'd3);
        chk("rdy_after_pop", 32'(rdy_tx),   32'd1);
        check_frame(8'h03);
        check_frame(8'h04);
        check_frame(8'h05);
        @(negedge clk);
        chk("burst_busy_done", 32'(busy),     32'd0);
        chk("burst_txd_done",  32'(txd),      32'd1);
        chk("burst_cnt_done",  32'(fifo_cnt), 32'd0);
      end
    join

    // Reset in the middle of a data bit with one word still queued
    push_one(8'h3C);
    push_one(8'h55);
    repeat (12) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    chk("midrst_txd",  32'(txd),      32'd1);
    chk("midrst_cnt",  32'(fifo_cnt), 32'd0);
    chk("midrst_rdy",  32'(rdy_tx),   32'd1);
    chk("midrst_busy", 32'(busy),     32'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("postrst_txd",  32'(txd),  32'd1);
      chk("postrst_busy", 32'(busy), 32'd0);
    end
    push_one(8'h96);
    check_frame(8'h96);
    @(negedge clk);
    chk("96_busy_done", 32'(busy), 32'd0);

`ifdef UART_TX_PARITY_EN
    push_one(8'h07);
    check_frame(8'h07);
    @(negedge clk);
    chk("07_busy_done", 32'(busy), 32'd0);
    chk("07_txd_done",  32'(txd),  32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
